// File: rtl/tamper_event_monitor_if.sv
// Bundle between tamper flag sources / system controller and the tamper event monitor.
// master drives the raw flags and controls, slave is the monitor itself.
interface tamper_event_monitor_if #(
   parameter int NUM_CH = 8
);
   logic [NUM_CH-1:0] event_in;
   logic              clear;
   logic [NUM_CH-1:0] clear_mask;
   logic              zeroize_ack;
   logic [NUM_CH-1:0] event_latched;
   logic [3:0]        detect_category;
   logic              detect_valid;
   logic              tamper_change_strobe;
   logic [7:0]        event_count;
   logic              lockdown_all_n;
   logic              disable_all_ios_n;
   logic              zeroize_n;
   logic [2:0]        state;

   modport master (
      output event_in, clear, clear_mask, zeroize_ack,
      input  event_latched, detect_category, detect_valid, tamper_change_strobe,
             event_count, lockdown_all_n, disable_all_ios_n, zeroize_n, state
   );

   modport slave (
      input  event_in, clear, clear_mask, zeroize_ack,
      output event_latched, detect_category, detect_valid, tamper_change_strobe,
             event_count, lockdown_all_n, disable_all_ios_n, zeroize_n, state
   );
endinterface

// File: rtl/tamper_event_monitor.sv
// Tamper event filter/latch with priority category report and a lockdown/zeroize
// response sequencer.
//
// state      | meaning
// IDLE       | no lockdown-class event latched, all requests released
// LOCKDOWN   | lockdown requested, IOs disabled if an IO-class event is latched
// ZERO_PEND  | zeroize countdown running, cancelled if zeroize events are cleared
// ZEROIZE    | zeroize requested, waiting for acknowledge
// DONE       | zeroize acknowledged, held until reset
module tamper_event_monitor #(
   parameter int                NUM_CH        = 8,
   parameter int                FILTER_CYCLES = 4,
   parameter logic [NUM_CH-1:0] LOCKDOWN_MASK = {NUM_CH{1'b1}},
   parameter logic [NUM_CH-1:0] IOS_MASK      = '0,
   parameter logic [NUM_CH-1:0] ZEROIZE_MASK  = '0,
   parameter int                ZEROIZE_DELAY = 16
) (
   input logic                   clk,
   input logic                   reset,
   tamper_event_monitor_if.slave bus
);

   localparam int             CW       = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0]  FILT_TC  = CW'(FILTER_CYCLES);
   localparam int             TW       = (ZEROIZE_DELAY > 1) ? $clog2(ZEROIZE_DELAY) : 1;
   localparam logic [TW-1:0]  TMR_LOAD = TW'(ZEROIZE_DELAY - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOCKDOWN  = 3'd1,
      ST_ZERO_PEND = 3'd2,
      ST_ZEROIZE   = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     filt_cnt [NUM_CH];
   logic [NUM_CH-1:0] qual;
   logic [NUM_CH-1:0] latched;
   logic [NUM_CH-1:0] latched_d;
   logic [NUM_CH-1:0] latched_nxt;
   logic              clear_en;
   logic              qual_any_q;
   logic [3:0]        category;
   logic              valid;
   logic              strobe;
   logic [7:0]        count;
   logic [TW-1:0]     zero_tmr;
   logic              lockdown_n;
   logic              dis_ios_n;
   logic              zero_n;
   logic              l_any;
   logic              z_any;
   logic              i_any;

   function automatic logic [3:0] lowest_idx(input logic [NUM_CH-1:0] v);
      lowest_idx = 4'd0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (v[i]) lowest_idx = 4'(i);
   endfunction

   // A channel qualifies only on the sample that brings its counter to terminal count,
   // so a long high run produces a single qualification.
   always_comb begin
      qual = '0;
      for (int i = 0; i < NUM_CH; i++)
         qual[i] = bus.event_in[i] && (filt_cnt[i] == FILT_TC - CW'(1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) filt_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!bus.event_in[i])          filt_cnt[i] <= '0;
            else if (filt_cnt[i] != FILT_TC) filt_cnt[i] <= filt_cnt[i] + CW'(1);
         end
      end
   end

   assign clear_en    = bus.clear && (state != ST_ZEROIZE) && (state != ST_DONE);
   assign latched_nxt = (latched & ~(clear_en ? bus.clear_mask : '0)) | qual;

   always_ff @(posedge clk) begin
      if (reset) begin
         latched    <= '0;
         latched_d  <= '0;
         qual_any_q <= 1'b0;
         category   <= 4'd0;
         valid      <= 1'b0;
         strobe     <= 1'b0;
         count      <= 8'd0;
      end else begin
         latched    <= latched_nxt;
         latched_d  <= latched;
         qual_any_q <= |qual;
         category   <= lowest_idx(latched);
         valid      <= |latched;
         strobe     <= (latched != latched_d);
         if (qual_any_q && (count != 8'hff)) count <= count + 8'd1;
      end
   end

   assign l_any = |(latched & LOCKDOWN_MASK);
   assign z_any = |(latched & ZEROIZE_MASK);
   assign i_any = |(latched & IOS_MASK);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (z_any)      state_nxt = ST_ZERO_PEND;
            else if (l_any) state_nxt = ST_LOCKDOWN;
         end
         ST_LOCKDOWN: begin
            if (z_any)       state_nxt = ST_ZERO_PEND;
            else if (!l_any) state_nxt = ST_IDLE;
         end
         ST_ZERO_PEND: begin
            if (!z_any)               state_nxt = l_any ? ST_LOCKDOWN : ST_IDLE;
            else if (zero_tmr == '0)  state_nxt = ST_ZEROIZE;
         end
         ST_ZEROIZE: begin
            if (bus.zeroize_ack) state_nxt = ST_ZEROIZE;
            if (bus.zeroize_ack) state_nxt = ST_DONE;
         end
         ST_DONE:    state_nxt = ST_DONE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Request outputs are registered from the next state so they align with STATE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         zero_tmr   <= '0;
         lockdown_n <= 1'b1;
         dis_ios_n  <= 1'b1;
         zero_n     <= 1'b1;
      end else begin
         state <= state_nxt;
         if ((state_nxt == ST_ZERO_PEND) && (state != ST_ZERO_PEND))
            zero_tmr <= TMR_LOAD;
         else if ((state == ST_ZERO_PEND) && (zero_tmr != '0))
            zero_tmr <= zero_tmr - TW'(1);
         lockdown_n <= (state_nxt == ST_IDLE);
         zero_n     <= (state_nxt != ST_ZEROIZE);
         dis_ios_n  <= !((state_nxt == ST_ZEROIZE) || (state_nxt == ST_DONE) ||
                         (((state_nxt == ST_LOCKDOWN) || (state_nxt == ST_ZERO_PEND)) && i_any));
      end
   end

   assign bus.event_latched        = latched;
   assign bus.detect_category      = category;
   assign bus.detect_valid         = valid;
   assign bus.tamper_change_strobe = strobe;
   assign bus.event_count          = count;
   assign bus.lockdown_all_n       = lockdown_n;
   assign bus.disable_all_ios_n    = dis_ios_n;
   assign bus.zeroize_n            = zero_n;
   assign bus.state                = state;

endmodule

// File: tb/tb_tamper_event_monitor.sv
// Bench for tamper_event_monitor: directed scenarios plus random traffic, all outputs
// compared every cycle against a cycle-level model built from the behavioural rules.
module tb_tamper_event_monitor;

   localparam int         NCH = 8;
   localparam int         FC  = 4;
   localparam int         ZD  = 16;
   localparam logic [7:0] LM  = 8'hFF;
   localparam logic [7:0] IM  = 8'h08;
   localparam logic [7:0] ZM  = 8'h01;

   logic clk = 1'b0;
   logic reset = 1'b1;

   tamper_event_monitor_if #(.NUM_CH(NCH)) bus ();

   tamper_event_monitor #(
      .NUM_CH(NCH), .FILTER_CYCLES(FC), .LOCKDOWN_MASK(LM),
      .IOS_MASK(IM), .ZEROIZE_MASK(ZM), .ZEROIZE_DELAY(ZD)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // model: run lengths, latched set, state as number, cycles spent waiting to zeroize
   int         run [NCH];
   logic [7:0] m_lat;
   int         m_st, m_age, m_cnt;
   bit         m_chg, m_qual;
   int         e_cat;
   bit         e_valid, e_strobe, e_lock, e_dis, e_zero;

   int cyc_n = 0;
   int t_pend, t_zero;
   bit zero_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask

   function automatic int first_set(input logic [7:0] v);
      for (int i = 0; i < NCH; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) run[i] = 0;
      m_lat = '0; m_st = 0; m_age = 0; m_cnt = 0; m_chg = 0; m_qual = 0;
      e_cat = 0; e_valid = 0; e_strobe = 0; e_lock = 1; e_dis = 1; e_zero = 1;
   endtask

   task automatic model_step();
      logic [7:0] q, nl;
      int ns;
      bit z, l, io;
      if (reset) begin
         model_reset();
         return;
      end
      q = '0;
      for (int i = 0; i < NCH; i++) begin
         if (bus.event_in[i]) begin
            if (run[i] < 1000) run[i]++;
            if (run[i] == FC) q[i] = 1'b1;
         end else run[i] = 0;
      end
      nl = m_lat;
      if (bus.clear && m_st != 3 && m_st != 4) nl = nl & ~bus.clear_mask;
      nl = nl | q;
      e_cat    = first_set(m_lat);
      e_valid  = (m_lat != 0);
      e_strobe = m_chg;
      if (m_qual && m_cnt < 255) m_cnt++;
      z  = (m_lat & ZM) != 0;
      l  = (m_lat & LM) != 0;
      io = (m_lat & IM) != 0;
      ns = m_st;
      case (m_st)
         0: if (z) begin ns = 2; m_age = 0; end else if (l) ns = 1;
         1: if (z) begin ns = 2; m_age = 0; end else if (!l) ns = 0;
         2: if (!z) ns = l ? 1 : 0;
            else begin
               m_age++;
               if (m_age == ZD) ns = 3;
            end
         3: if (bus.zeroize_ack) ns = 4;
         default: ns = m_st;
      endcase
      e_lock = (ns == 0);
      e_zero = (ns != 3);
      e_dis  = !((ns == 3) || (ns == 4) || (((ns == 1) || (ns == 2)) && io));
      m_chg  = (nl != m_lat);
      m_qual = (q != 0);
      m_lat  = nl;
      m_st   = ns;
   endtask

   task automatic check_all();
      chk("latched",  bus.event_latched, m_lat);
      chk("category", bus.detect_category, e_cat);
      chk("valid",    bus.detect_valid, e_valid);
      chk("strobe",   bus.tamper_change_strobe, e_strobe);
      chk("count",    bus.event_count, m_cnt);
      chk("lock_n",   bus.lockdown_all_n, e_lock);
      chk("dis_n",    bus.disable_all_ios_n, e_dis);
      chk("zero_n",   bus.zeroize_n, e_zero);
      chk("state",    bus.state, m_st);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc_n++;
      check_all();
      if (bus.state == 3'd2 && t_pend < 0) t_pend = cyc_n;
      if (!bus.zeroize_n && t_zero < 0)    t_zero = cyc_n;
      if (!bus.zeroize_n)                   zero_seen = 1;
   endtask

   task automatic do_reset();
      reset = 1; bus.event_in = '0; bus.clear = 0; bus.clear_mask = '0; bus.zeroize_ack = 0;
      cyc(); cyc();
      reset = 0;
   endtask

   task automatic qualify(input int ch);
      bus.event_in = 8'(1 << ch);
      repeat (FC) cyc();
      bus.event_in = '0;
      cyc();
   endtask

   task automatic clear_bits(input logic [7:0] m);
      bus.clear = 1; bus.clear_mask = m;
      cyc();
      bus.clear = 0; bus.clear_mask = '0;
      cyc();
   endtask

   task automatic wait_state(input logic [2:0] target, input int maxc, input string tag);
      int n = 0;
      while (bus.state != target && n < maxc) begin
         cyc();
         n++;
      end
      chk(tag, bus.state, target);
   endtask

   initial begin
      t_pend = -1; t_zero = -1; zero_seen = 0;
      bus.event_in = '0; bus.clear = 0; bus.clear_mask = '0; bus.zeroize_ack = 0;
      model_reset();
      do_reset();
      chk("rst_state", bus.state, 0);
      chk("rst_lock_n", bus.lockdown_all_n, 1);

      // short run does not qualify, full run does
      bus.event_in = 8'h04; repeat (3) cyc();
      bus.event_in = 8'h00; cyc();
      bus.event_in = 8'h04; repeat (3) cyc();
      chk("no_early_latch", bus.event_latched, 8'h00);
      cyc();
      chk("latch_ch2", bus.event_latched, 8'h04);
      bus.event_in = 8'h00; cyc();
      chk("cat_ch2", bus.detect_category, 2);
      chk("valid_ch2", bus.detect_valid, 1);
      chk("strobe_ch2", bus.tamper_change_strobe, 1);
      chk("count_1", bus.event_count, 1);
      chk("lock_ch2", bus.lockdown_all_n, 0);
      cyc();
      chk("strobe_once", bus.tamper_change_strobe, 0);

      // priority reporting and clearing
      clear_bits(8'h04);
      qualify(5);
      chk("cat_5", bus.detect_category, 5);
      qualify(1);
      chk("cat_1", bus.detect_category, 1);
      clear_bits(8'h02);
      chk("cat_back_5", bus.detect_category, 5);
      chk("strobe_clr", bus.tamper_change_strobe, 1);
      clear_bits(8'h20);
      chk("valid_off", bus.detect_valid, 0);
      chk("idle_again", bus.state, 0);
      chk("lock_rel", bus.lockdown_all_n, 1);

      // zeroize countdown and acknowledge
      do_reset();
      t_pend = -1; t_zero = -1;
      bus.event_in = 8'h01; repeat (FC) cyc();
      bus.event_in = 8'h00;
      wait_state(3'd3, 40, "reach_zeroize");
      chk("zero_delay", t_zero - t_pend, ZD);
      clear_bits(8'h01);
      chk("clr_ign_zeroize", bus.event_latched, 8'h01);
      bus.zeroize_ack = 1; cyc();
      bus.zeroize_ack = 0; cyc();
      chk("done_state", bus.state, 4);
      chk("done_zero_n", bus.zeroize_n, 1);
      chk("done_lock_n", bus.lockdown_all_n, 0);
      chk("done_dis_n", bus.disable_all_ios_n, 0);
      clear_bits(8'h01);
      chk("clr_ign_done", bus.event_latched, 8'h01);

      // countdown cancelled by clear at countdown cycle 10
      do_reset();
      zero_seen = 0; t_pend = -1;
      bus.event_in = 8'h01; repeat (FC) cyc();
      bus.event_in = 8'h00;
      wait_state(3'd2, 10, "reach_pend");
      repeat (9) cyc();
      bus.clear = 1; bus.clear_mask = 8'h01; cyc();
      bus.clear = 0; bus.clear_mask = 8'h00;
      repeat (20) cyc();
      chk("cancel_idle", bus.state, 0);
      chk("cancel_no_zero", zero_seen, 0);

      // set wins over clear, then saturation of the qualification count
      bus.event_in = 8'h10; repeat (FC - 1) cyc();
      bus.clear = 1; bus.clear_mask = 8'h10; cyc();
      bus.clear = 0; bus.clear_mask = 8'h00; bus.event_in = 8'h00; cyc();
      chk("set_wins", bus.event_latched[4], 1);
      chk("io_lockdown_dis", bus.disable_all_ios_n, 1);
      qualify(3);
      chk("io_dis_n", bus.disable_all_ios_n, 0);
      repeat (300) begin
         bus.event_in = 8'h40; repeat (FC) cyc();
         bus.event_in = 8'h00; cyc();
      end
      cyc();
      chk("count_sat", bus.event_count, 255);

      // random traffic
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < NCH; i++)
            if ($urandom_range(0, 4) == 0) bus.event_in[i] = ~bus.event_in[i];
         bus.clear       = ($urandom_range(0, 7) == 0);
         bus.clear_mask  = 8'($urandom);
         bus.zeroize_ack = ($urandom_range(0, 3) == 0);
         reset           = ($urandom_range(0, 299) == 0);
         cyc();
      end
      reset = 0; bus.clear = 0; bus.zeroize_ack = 0;

      // reset while zeroizing
      do_reset();
      bus.event_in = 8'h01; repeat (FC) cyc();
      bus.event_in = 8'h00;
      wait_state(3'd3, 40, "reach_zeroize2");
      reset = 1; cyc();
      chk("rz_zero_n", bus.zeroize_n, 1);
      chk("rz_lock_n", bus.lockdown_all_n, 1);
      chk("rz_dis_n", bus.disable_all_ios_n, 1);
      chk("rz_state", bus.state, 0);
      chk("rz_latched", bus.event_latched, 0);
      chk("rz_count", bus.event_count, 0);
      reset = 0; cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
